// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply controller slice: FSM encoding and
// a width helper used to size shared buses and counters.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matmul_datapath.sv
// Reference multiply datapath: combinational product followed by a LATENCY-deep
// register pipeline that only advances while cen is high.
module matmul_datapath #(
  parameter int unsigned R1      = 2,
  parameter int unsigned C1      = 2,
  parameter int unsigned C2      = 2,
  parameter int unsigned W_A     = 3,
  parameter int unsigned W_B     = 3,
  parameter int unsigned W_C     = W_A + W_B + $clog2(C1),
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mm_cen,
  input  logic [R1*C1*W_A-1:0] mm_A,
  input  logic [C1*C2*W_B-1:0] mm_B,
  output logic [R1*C2*W_C-1:0] mm_C
);

  localparam int unsigned CWID = R1 * C2 * W_C;

  logic [CWID-1:0] prod;
  logic [W_C-1:0]  acc;
  logic [CWID-1:0] pipe [LATENCY];

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int unsigned i = 0; i < R1; i++) begin
      for (int unsigned j = 0; j < C2; j++) begin
        acc = '0;
        for (int unsigned k = 0; k < C1; k++)
          acc = acc + W_C'(mm_A[(i*C1+k)*W_A +: W_A]) * W_C'(mm_B[(k*C2+j)*W_B +: W_B]);
        prod[(i*C2+j)*W_C +: W_C] = acc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < LATENCY; s++) pipe[s] <= '0;
    end else if (mm_cen) begin
      pipe[0] <= prod;
      for (int unsigned s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign mm_C = pipe[LATENCY-1];

endmodule

// File: rtl/matmul_system.sv
// Pairs the stream controller with the multiply datapath.
module matmul_system
  import matmul_pkg::*;
#(
  parameter int unsigned R1      = 2,
  parameter int unsigned C1      = 2,
  parameter int unsigned R2      = 2,
  parameter int unsigned C2      = 2,
  parameter int unsigned W_A     = 3,
  parameter int unsigned W_B     = 3,
  parameter int unsigned W_C     = W_A + W_B + $clog2(C1),
  parameter int unsigned LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [max2(W_A, W_B)-1:0] s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [W_C-1:0]            m_data,
  output logic                      m_last,
  output logic                      busy
);

  logic                 cen;
  logic [R1*C1*W_A-1:0] a_bus;
  logic [R2*C2*W_B-1:0] b_bus;
  logic [R1*C2*W_C-1:0] c_bus;

  matmul_ctrl #(
    .R1(R1), .C1(C1), .R2(R2), .C2(C2),
    .W_A(W_A), .W_B(W_B), .W_C(W_C), .LATENCY(LATENCY)
  ) u_ctrl (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .mm_cen(cen), .mm_A(a_bus), .mm_B(b_bus), .mm_C(c_bus),
    .busy(busy)
  );

  matmul_datapath #(
    .R1(R1), .C1(C1), .C2(C2),
    .W_A(W_A), .W_B(W_B), .W_C(W_C), .LATENCY(LATENCY)
  ) u_dp (
    .clk(clk), .rst(rst),
    .mm_cen(cen), .mm_A(a_bus), .mm_B(b_bus), .mm_C(c_bus)
  );

endmodule

// File: rtl/matmul_ctrl.sv
// Streams A and B operands in row-major order, holds them for an external
// multiply datapath, then streams the captured C matrix out element by element.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned R1      = 2,
  parameter int unsigned C1      = 2,
  parameter int unsigned R2      = 2,
  parameter int unsigned C2      = 2,
  parameter int unsigned W_A     = 3,
  parameter int unsigned W_B     = 3,
  parameter int unsigned W_C     = W_A + W_B + $clog2(C1),
  parameter int unsigned LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [max2(W_A, W_B)-1:0]     s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [W_C-1:0]                m_data,
  output logic                          m_last,
  output logic                          mm_cen,
  output logic [R1*C1*W_A-1:0]          mm_A,
  output logic [R2*C2*W_B-1:0]          mm_B,
  input  logic [R1*C2*W_C-1:0]          mm_C,
  output logic                          busy
);

  localparam int unsigned NA = R1 * C1;
  localparam int unsigned NB = R2 * C2;
  localparam int unsigned NC = R1 * C2;
  localparam int unsigned CW = $clog2(max2(max2(NA, NB), max2(NC, LATENCY + 1)));

  if (C1 != R2) begin : g_bad_dims
    $error("matmul_ctrl: C1 (%0d) must equal R2 (%0d)", C1, R2);
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("matmul_ctrl: LATENCY must be at least 1");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W_A-1:0]  a_mem [NA];
  logic [W_B-1:0]  b_mem [NB];
  logic [W_C-1:0]  c_mem [NC];
  logic            s_fire;
  logic            m_fire;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int unsigned k = 0; k < NA; k++) a_mem[k] <= '0;
      for (int unsigned k = 0; k < NB; k++) b_mem[k] <= '0;
      for (int unsigned k = 0; k < NC; k++) c_mem[k] <= '0;
    end else begin
      unique case (state)
        IDLE: if (s_fire) begin
          a_mem[0] <= s_data[W_A-1:0];
          // A single-element A is already complete after the first beat.
          if (NA == 1) begin
            state <= LOAD_B;
            cnt   <= '0;
          end else begin
            state <= LOAD_A;
            cnt   <= CW'(1);
          end
        end
        LOAD_A: if (s_fire) begin
          for (int unsigned k = 0; k < NA; k++)
            if (cnt == CW'(k)) a_mem[k] <= s_data[W_A-1:0];
          if (cnt == CW'(NA - 1)) begin
            state <= LOAD_B;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD_B: if (s_fire) begin
          for (int unsigned k = 0; k < NB; k++)
            if (cnt == CW'(k)) b_mem[k] <= s_data[W_B-1:0];
          if (cnt == CW'(NB - 1)) begin
            state <= COMPUTE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        COMPUTE: begin
          if (cnt == CW'(LATENCY)) begin
            for (int unsigned k = 0; k < NC; k++) c_mem[k] <= mm_C[k*W_C +: W_C];
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DRAIN: if (m_fire) begin
          if (cnt == CW'(NC - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mm_A = '0;
    for (int unsigned k = 0; k < NA; k++) mm_A[k*W_A +: W_A] = a_mem[k];
    mm_B = '0;
    for (int unsigned k = 0; k < NB; k++) mm_B[k*W_B +: W_B] = b_mem[k];
    m_data = '0;
    for (int unsigned k = 0; k < NC; k++)
      if (cnt == CW'(k)) m_data = c_mem[k];
  end

  assign s_ready = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
  assign m_valid = (state == DRAIN);
  assign m_last  = (state == DRAIN) && (cnt == CW'(NC - 1));
  assign mm_cen  = (state == COMPUTE) && (cnt != CW'(LATENCY));
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl with default 2x2 parameters; the datapath side is a
// behavioural multiplier that only presents a correct C after LATENCY cen cycles.
module tb_matmul_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [2:0]  s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [6:0]  m_data;
  logic        m_last;
  logic        mm_cen;
  logic [11:0] mm_A;
  logic [11:0] mm_B;
  logic [27:0] mm_C;
  logic        busy;

  logic        sys_s_ready, sys_m_valid, sys_m_last, sys_busy;
  logic [6:0]  sys_m_data;

  int errors = 0;
  int checks = 0;

  int unsigned ja [4];
  int unsigned jb [4];
  int unsigned exp_c [4];

  int unsigned obs_data [$];
  int unsigned obs_sys [$];
  logic        obs_last [$];
  int          obs_cen, obs_stall_bad, obs_sready_bad, obs_extra, obs_beats_at_compute;
  int          cen_cnt = 0;

  always #5 clk = ~clk;

  matmul_ctrl #(.R1(2), .C1(2), .R2(2), .C2(2), .W_A(3), .W_B(3), .W_C(7), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .mm_cen(mm_cen), .mm_A(mm_A), .mm_B(mm_B), .mm_C(mm_C),
    .busy(busy)
  );

  matmul_system #(.R1(2), .C1(2), .R2(2), .C2(2), .W_A(3), .W_B(3), .W_C(7), .LATENCY(LAT)) sys (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(sys_s_ready), .s_data(s_data),
    .m_valid(sys_m_valid), .m_ready(m_ready), .m_data(sys_m_data), .m_last(sys_m_last),
    .busy(sys_busy)
  );

  function automatic logic [27:0] prod_of(input logic [11:0] a, input logic [11:0] b);
    logic [27:0] r;
    int unsigned s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s += int'(a[(i*2+k)*3 +: 3]) * int'(b[(k*2+j)*3 +: 3]);
        r[(i*2+j)*7 +: 7] = 7'(s);
      end
    return r;
  endfunction

  // C is garbage (inverted) until the datapath has seen LAT enabled cycles.
  always @(posedge clk) begin
    if (rst || !busy) cen_cnt <= 0;
    else if (mm_cen) cen_cnt <= cen_cnt + 1;
  end
  assign mm_C = (cen_cnt >= LAT) ? prod_of(mm_A, mm_B) : ~prod_of(mm_A, mm_B);

  task automatic model_expect();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        exp_c[i*2+j] = 0;
        for (int k = 0; k < 2; k++) exp_c[i*2+j] += ja[i*2+k] * jb[k*2+j];
      end
  endtask

  task automatic random_ops();
    for (int k = 0; k < 4; k++) begin
      ja[k] = $urandom_range(7);
      jb[k] = $urandom_range(7);
    end
  endtask

  // Drives one job (8 operand beats) and records what the result stream did.
  // rmode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random ready.
  task automatic run_job(input int gap, input int rmode, input bit hold);
    int idx = 0;
    int drain_cyc = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [6:0] prev_data = '0;
    obs_data.delete(); obs_sys.delete(); obs_last.delete();
    obs_cen = 0; obs_stall_bad = 0; obs_sready_bad = 0; obs_extra = 0;
    obs_beats_at_compute = -1;
    while (obs_data.size() < 4 && cyc < 300) begin
      if (idx < 8) begin
        if (gap > 0 && $urandom_range(99) < gap) begin
          s_valid = 1'b0;
          s_data  = 3'($urandom);
        end else begin
          s_valid = 1'b1;
          s_data  = 3'(idx < 4 ? ja[idx] : jb[idx-4]);
        end
      end else begin
        s_valid = hold;
        s_data  = 3'($urandom);
      end
      if (m_valid) begin
        case (rmode)
          0:       m_ready = 1'b1;
          1:       m_ready = (drain_cyc % 3 == 0);
          default: m_ready = 1'($urandom_range(1));
        endcase
        drain_cyc++;
      end else begin
        m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
      end
      if (mm_cen) begin
        obs_cen++;
        if (obs_beats_at_compute < 0) obs_beats_at_compute = idx;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data)) obs_stall_bad++;
      if (idx == 8 && s_ready) obs_sready_bad++;
      if (s_valid && s_ready) begin
        if (idx < 8) idx++;
        else obs_extra++;
      end
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data);
        obs_last.push_back(m_last);
        obs_sys.push_back(sys_m_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (mm_cen !== 1'b0) begin errors++; $display("FAIL reset_mm_cen: got %b want 0", mm_cen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (mm_A !== 12'd0 || mm_B !== 12'd0) begin errors++; $display("FAIL reset_operands: got A=%h B=%h want 0", mm_A, mm_B); end
    checks++; if (m_data !== 7'd0) begin errors++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got s_ready=%b busy=%b want 1/0", s_ready, busy); end
  endtask

  task automatic test_basic();
    ja = '{1, 2, 3, 4};
    jb = '{5, 6, 7, 0};
    model_expect();
    run_job(0, 0, 1'b0);
    checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL basic_beats: got %0d want 4", obs_data.size()); end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++; if (obs_data[k] !== exp_c[k]) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", k, obs_data[k], exp_c[k]); end
      checks++; if (obs_last[k] !== (k == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", k, obs_last[k], (k == 3)); end
      checks++; if (obs_sys[k] !== exp_c[k]) begin errors++; $display("FAIL system_data[%0d]: got %0d want %0d", k, obs_sys[k], exp_c[k]); end
    end
    checks++; if (obs_cen != LAT) begin errors++; $display("FAIL basic_cen_cycles: got %0d want %0d", obs_cen, LAT); end
    checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_return_idle: got s_ready=%b busy=%b want 1/0", s_ready, busy); end
  endtask

  task automatic test_backpressure();
    ja = '{1, 2, 3, 4};
    jb = '{5, 6, 7, 0};
    model_expect();
    run_job(0, 1, 1'b0);
    checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL bp_beats: got %0d want 4", obs_data.size()); end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++; if (obs_data[k] !== exp_c[k]) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, obs_data[k], exp_c[k]); end
    end
    checks++; if (obs_stall_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalled cycles want 0", obs_stall_bad); end
  endtask

  task automatic test_saturation();
    ja = '{7, 7, 7, 7};
    jb = '{7, 7, 7, 7};
    model_expect();
    run_job(0, 0, 1'b0);
    checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL sat_beats: got %0d want 4", obs_data.size()); end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++; if (obs_data[k] !== exp_c[k]) begin errors++; $display("FAIL sat_data[%0d]: got %0d want %0d", k, obs_data[k], exp_c[k]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 3'($urandom_range(1, 7));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL midreset_state: got busy=%b s_ready=%b m_valid=%b want 0/1/0", busy, s_ready, m_valid); end
    checks++; if (mm_A !== 12'd0 || mm_B !== 12'd0) begin errors++; $display("FAIL midreset_operands: got A=%h B=%h want 0", mm_A, mm_B); end
    ja = '{1, 0, 0, 1};
    jb = '{2, 3, 4, 5};
    model_expect();
    run_job(0, 0, 1'b0);
    checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL midreset_beats: got %0d want 4", obs_data.size()); end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++; if (obs_data[k] !== exp_c[k]) begin errors++; $display("FAIL midreset_data[%0d]: got %0d want %0d", k, obs_data[k], exp_c[k]); end
    end
    checks++; if (obs_beats_at_compute != 8) begin errors++; $display("FAIL midreset_compute_entry: got %0d beats want 8", obs_beats_at_compute); end
  endtask

  task automatic test_busy_window();
    random_ops();
    model_expect();
    run_job(0, 2, 1'b1);
    checks++; if (obs_sready_bad != 0) begin errors++; $display("FAIL busy_s_ready: got %0d busy cycles with s_ready=1 want 0", obs_sready_bad); end
    checks++; if (obs_extra != 0) begin errors++; $display("FAIL busy_accepted: got %0d extra beats want 0", obs_extra); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL busy_release: got s_ready=%b want 1", s_ready); end
    for (int k = 0; k < obs_data.size(); k++) begin
      checks++; if (obs_data[k] !== exp_c[k]) begin errors++; $display("FAIL busy_data[%0d]: got %0d want %0d", k, obs_data[k], exp_c[k]); end
    end
  endtask

  task automatic test_gaps();
    for (int job = 0; job < 4; job++) begin
      random_ops();
      model_expect();
      run_job(40, 2, 1'b0);
      checks++; if (obs_beats_at_compute != 8) begin errors++; $display("FAIL gaps_compute_entry[%0d]: got %0d beats want 8", job, obs_beats_at_compute); end
      checks++; if (obs_cen != LAT) begin errors++; $display("FAIL gaps_cen_cycles[%0d]: got %0d want %0d", job, obs_cen, LAT); end
      checks++; if (obs_data.size() != 4) begin errors++; $display("FAIL gaps_beats[%0d]: got %0d want 4", job, obs_data.size()); end
      for (int k = 0; k < obs_data.size(); k++) begin
        checks++; if (obs_data[k] !== exp_c[k]) begin errors++; $display("FAIL gaps_data[%0d][%0d]: got %0d want %0d", job, k, obs_data[k], exp_c[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_busy_window();
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 The block SHALL have parameter R1, default 2, meaning rows of A.
REQ-002 The block SHALL have parameter C1, default 2, meaning columns of A; elaboration SHALL fail if C1 != R2.
REQ-003 The block SHALL have parameter R2, default 2, meaning rows of B.
REQ-004 The block SHALL have parameter C2, default 2, meaning columns of B.
REQ-005 The block SHALL have parameters W_A and W_B, default 3 each, meaning element widths of A and B.
REQ-006 The block SHALL have parameter W_C, default W_A+W_B+$clog2(C1), meaning result element width.
REQ-007 The block SHALL have parameter LATENCY, default 2, meaning cen-high cycles the datapath needs before C is valid; legal range is >=1.
REQ-008 Port clk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-009 Port rst: input, 1 bit; reset is synchronous and active-high.
REQ-010 Ports s_valid (in, 1), s_ready (out, 1) and s_data (in, max(W_A,W_B)) SHALL form the operand stream.
REQ-011 Ports m_valid (out, 1), m_ready (in, 1), m_data (out, W_C) and m_last (out, 1) SHALL form the result stream.
REQ-012 Ports mm_cen (out, 1), mm_A (out, R1*C1*W_A), mm_B (out, R2*C2*W_B) and mm_C (in, R1*C2*W_C) SHALL form the datapath side.
REQ-013 Port busy: output, 1 bit, high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, COMPUTE and DRAIN, with a single element counter cnt shared by all states.
REQ-015 A beat SHALL transfer on a cycle where s_valid and s_ready are both high; likewise where m_valid and m_ready are both high.
REQ-016 In IDLE, s_ready SHALL be 1, and the first accepted beat SHALL be stored as A element 0 and move the FSM to LOAD_A.
REQ-017 A and B SHALL be loaded row-major, with element k at bits [k*W +: W] of mm_A/mm_B; only the low W_A (W_B) bits of s_data SHALL be kept.
REQ-018 LOAD_A SHALL accept beats until R1*C1 A elements are held, then go to LOAD_B with cnt=0.
REQ-019 LOAD_B SHALL accept R2*C2 beats and go to COMPUTE with cnt=0 after the last one.
REQ-020 s_ready SHALL be 0 in COMPUTE and DRAIN, so no new operands are taken while a job is active.
REQ-021 mm_A and mm_B SHALL come straight from the operand registers and SHALL stay stable from the end of LOAD_B until the FSM returns to IDLE.
REQ-022 In COMPUTE, mm_cen SHALL be 1 while cnt<LATENCY and 0 when cnt==LATENCY.
REQ-023 When cnt==LATENCY, mm_C SHALL be captured into a result register and the FSM SHALL move to DRAIN; COMPUTE therefore lasts exactly LATENCY+1 cycles.
REQ-024 mm_cen SHALL be 0 in every state other than COMPUTE.
REQ-025 In DRAIN, m_valid SHALL be 1 and m_data SHALL be result element cnt in row-major order.
REQ-026 m_data and m_valid SHALL hold steady while m_ready=0.
REQ-027 m_last SHALL be 1 only on element R1*C2-1.
REQ-028 After the last element transfers, the FSM SHALL return to IDLE, and s_ready SHALL be 1 on the next cycle.
REQ-029 No arithmetic SHALL be done in the block; widths SHALL pass through unchanged.
REQ-030 cnt SHALL be $clog2(max(R1*C1, R2*C2, R1*C2, LATENCY+1)) bits wide and SHALL never wrap inside a state.

Reset
REQ-031 When rst=1 at a clock edge, the next state SHALL be IDLE and cnt SHALL be 0, even mid-load, mid-compute or mid-drain.
REQ-032 During and after reset, s_ready=1, m_valid=0, m_last=0, mm_cen=0 and busy=0.
REQ-033 Reset SHALL clear the operand and result registers to 0, so mm_A, mm_B and m_data read 0.
REQ-034 Any partially loaded job SHALL be discarded, and no result beat SHALL be emitted for it.

Structure
REQ-035 A shared package matmul_pkg SHALL hold the state enum (IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN) and a max-width helper constant or function.
REQ-036 The block SHALL contain no sub-modules; a separate top, matmul_system, SHALL instantiate matmul_ctrl and the matmul datapath side by side.

Verification
REQ-037 Basic job: stream A=1,2,3,4 then B=5,6,7,0 with m_ready=1 -> m_data 19,6,43,18, m_last on the 4th beat, and mm_cen high for exactly 2 cycles.
REQ-038 Backpressure: same job with m_ready toggling 1,0,0,1,... -> identical data order, and m_data held constant on every stalled cycle.
REQ-039 Saturation: all A and B elements =7 -> every result is 98, with no truncation at W_C=7.
REQ-040 Reset mid-operation: assert rst after 3 B beats, then stream a fresh job of A=1,0,0,1 with B=2,3,4,5 -> outputs 2,3,4,5 and no stale beat.
REQ-041 Busy window: present s_valid=1 continuously through COMPUTE and DRAIN -> s_ready=0 and no beat accepted until the cycle after the last result beat.
REQ-042 Input gaps: insert random s_valid gaps during LOAD_A and LOAD_B -> results unchanged, and COMPUTE entered only after exactly 8 accepted beats.
